// File: rtl/cory_s2tap_pad_pkg.sv
// Shared definitions for the sliding tap-window builder: padding modes and
// control states.
package cory_s2tap_pad_pkg;

    // Padding mode encodings carried on i_cmd_mode; the reserved code pads with zero.
    typedef enum logic [1:0] {
        PAD_ZERO  = 2'd0,
        PAD_REPL  = 2'd1,
        PAD_CONST = 2'd2,
        PAD_RSVD  = 2'd3
    } pad_mode_t;

    // Line control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/cory_s2tap_pad_win.sv
// T-slot shift register with first-load left fill plus a single-entry output
// register. Slot 0 is the oldest sample (x[k-PL]), slot T-1 the newest (x[k+PR]).
module cory_s2tap_pad_win #(
    parameter int N  = 8,
    parameter int PL = 2,
    parameter int PR = 3,
    localparam int T = PL + 1 + PR,
    localparam int W = N * T
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_v,      // a push is offered (sample or right pad)
    input  logic         in_first,  // first sample of a line: load left fill
    input  logic         in_emit,   // this push produces a window downstream
    input  logic [N-1:0] in_d,      // value entering the top slot
    input  logic [N-1:0] in_fill,   // left pad value used on the first load
    output logic         in_r,      // push can be taken this cycle
    output logic [N-1:0] top_d,     // current newest slot (right replicate source)
    output logic         out_v,
    output logic [W-1:0] out_d,
    input  logic         out_r
);

    logic [W-1:0] win_reg;
    logic [W-1:0] win_next;
    logic         out_v_reg;
    logic [W-1:0] out_d_reg;
    logic         push;

    // Suppressed pushes never touch the output register, so they never wait on it.
    assign in_r  = ~out_v_reg | out_r | ~in_emit;
    assign push  = in_v & in_r;
    assign top_d = win_reg[W-1 -: N];
    assign out_v = out_v_reg;
    assign out_d = out_d_reg;

    // Next window: shift toward slot 0 with the new value at the top; the first
    // sample instead seeds the PL slots below the top with the left pad.
    for (genvar gi = 0; gi < T; gi++) begin : g_slot
        if (gi == T - 1) begin : g_top
            assign win_next[gi*N +: N] = in_d;
        end else if (gi >= T - 1 - PL) begin : g_fill
            assign win_next[gi*N +: N] = in_first ? in_fill : win_reg[(gi+1)*N +: N];
        end else begin : g_low
            assign win_next[gi*N +: N] = in_first ? '0 : win_reg[(gi+1)*N +: N];
        end
    end

    // Shift register advances on every accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_reg <= '0;
        end else if (push) begin
            win_reg <= win_next;
        end
    end

    // Output register: load the freshly shifted window on emitting pushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_v_reg <= 1'b0;
            out_d_reg <= '0;
        end else if (push && in_emit) begin
            out_v_reg <= 1'b1;
            out_d_reg <= win_next;
        end else if (out_r) begin
            out_v_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/cory_s2tap_pad.sv
// Scalar stream to sliding filter-tap window converter with per-command
// left/right padding (zero, replicate-edge or constant).
module cory_s2tap_pad
    import cory_s2tap_pad_pkg::*;
#(
    parameter int N  = 8,
    parameter int PL = 2,
    parameter int PR = 3,
    parameter int R  = 11,
    localparam int T = PL + 1 + PR,
    localparam int W = N * T,
    localparam int P = $clog2(PR + 2)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_cmd_v,
    input  logic [R-1:0] i_cmd_cnt,
    input  logic [1:0]   i_cmd_mode,
    input  logic [N-1:0] i_cmd_pad,
    output logic         o_cmd_r,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [W-1:0] o_z_d,
    input  logic         i_z_r,
    output logic [R-1:0] o_z_cnt,
    output logic         o_z_last
);

    localparam logic [R-1:0] ONE_R      = R'(1);
    localparam logic [P-1:0] ONE_P      = P'(1);
    localparam logic [P-1:0] IGN_MAX    = P'(PR);
    localparam logic [P-1:0] FLUSH_LAST = P'((PR > 0) ? PR - 1 : 0);

    state_t       state_reg;
    logic         cmd_r_reg;
    logic [R-1:0] len_reg;
    logic [R-1:0] len_m1;
    pad_mode_t    mode_reg;
    logic [N-1:0] pad_reg;
    logic [R-1:0] samp_cnt_reg;   // samples accepted this line
    logic [P-1:0] ign_cnt_reg;    // suppressed pushes so far, saturates at PR
    logic [P-1:0] flush_cnt_reg;  // right pads pushed so far
    logic [R-1:0] k_reg;          // index of the next window to emit
    logic [R-1:0] z_cnt_reg;
    logic         z_last_reg;

    logic         win_in_v;
    logic         win_in_r;
    logic         win_first;
    logic         win_emit;
    logic [N-1:0] win_d;
    logic [N-1:0] win_top;
    logic [N-1:0] fill_val;
    logic [N-1:0] right_val;
    logic         push;

    assign len_m1    = len_reg - ONE_R;
    assign win_in_v  = ((state_reg == ST_LOAD) && i_a_v) || (state_reg == ST_FLUSH);
    assign win_first = (state_reg == ST_LOAD) && (samp_cnt_reg == '0);
    assign win_emit  = (ign_cnt_reg == IGN_MAX);
    assign win_d     = (state_reg == ST_FLUSH) ? right_val : i_a_d;
    assign push      = win_in_v && win_in_r;
    assign o_a_r     = (state_reg == ST_LOAD) && win_in_r;
    assign o_cmd_r   = cmd_r_reg;
    assign o_z_cnt   = z_cnt_reg;
    assign o_z_last  = z_last_reg;

    // Pad values: left fill comes from the first sample, right pad from the top slot.
    always_comb begin
        fill_val  = '0;
        right_val = '0;
        case (mode_reg)
            PAD_REPL: begin
                fill_val  = i_a_d;
                right_val = win_top;
            end
            PAD_CONST: begin
                fill_val  = pad_reg;
                right_val = pad_reg;
            end
            default: ;
        endcase
    end

    cory_s2tap_pad_win #(
        .N  (N),
        .PL (PL),
        .PR (PR)
    ) u_win (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_v     (win_in_v),
        .in_first (win_first),
        .in_emit  (win_emit),
        .in_d     (win_d),
        .in_fill  (fill_val),
        .in_r     (win_in_r),
        .top_d    (win_top),
        .out_v    (o_z_v),
        .out_d    (o_z_d),
        .out_r    (i_z_r)
    );

    // Line control FSM with command latches, push counters and window tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cmd_r_reg     <= 1'b1;
            len_reg       <= '0;
            mode_reg      <= PAD_ZERO;
            pad_reg       <= '0;
            samp_cnt_reg  <= '0;
            ign_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
            k_reg         <= '0;
            z_cnt_reg     <= '0;
            z_last_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_cmd_v) begin
                        len_reg       <= i_cmd_cnt;
                        mode_reg      <= pad_mode_t'(i_cmd_mode);
                        pad_reg       <= i_cmd_pad;
                        samp_cnt_reg  <= '0;
                        ign_cnt_reg   <= '0;
                        flush_cnt_reg <= '0;
                        k_reg         <= '0;
                        // An empty line is consumed without leaving IDLE.
                        if (i_cmd_cnt != '0) begin
                            state_reg <= ST_LOAD;
                            cmd_r_reg <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (push) begin
                        samp_cnt_reg <= samp_cnt_reg + ONE_R;
                        if (samp_cnt_reg == len_m1) begin
                            state_reg <= (PR == 0) ? ST_DRAIN : ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (push) begin
                        flush_cnt_reg <= flush_cnt_reg + ONE_P;
                        if (flush_cnt_reg == FLUSH_LAST) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (o_z_v && i_z_r && z_last_reg) begin
                        state_reg <= ST_IDLE;
                        cmd_r_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (push && !win_emit) begin
                ign_cnt_reg <= ign_cnt_reg + ONE_P;
            end
            if (push && win_emit) begin
                z_cnt_reg  <= k_reg;
                z_last_reg <= (k_reg == len_m1);
                k_reg      <= k_reg + ONE_R;
            end
        end
    end

`ifndef SYNTHESIS
    if (PR >= (1 << P) - 1) begin : g_pr_too_deep
        $error("cory_s2tap_pad: PR too large for the ignore counter width");
    end

    if (1) begin : cory_monitor
        logic             hold_reg;
        logic [W+R+1:0]   held_reg;

        // Track the previous cycle's output and whether it was stalled.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold_reg <= 1'b0;
                held_reg <= '0;
            end else begin
                hold_reg <= o_z_v && !i_z_r;
                held_reg <= {o_z_v, o_z_last, o_z_cnt, o_z_d};
                if (hold_reg) begin
                    assert ({o_z_v, o_z_last, o_z_cnt, o_z_d} == held_reg)
                        else $error("cory_s2tap_pad: output changed while stalled");
                end
                if (state_reg == ST_IDLE && i_cmd_v && pad_mode_t'(i_cmd_mode) == PAD_RSVD) begin
                    $warning("cory_s2tap_pad: reserved pad mode 3 treated as zero");
                end
            end
        end
    end
`endif

endmodule
